// File: rtl/clk_time_setter_pkg.sv
// Shared definitions for the front-panel time setter.
// Holds the FSM state encoding, the edit_field codes, the per-field
// maximum values and small decode helpers used by the top level.
package clk_set_defs;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } set_state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;
    localparam int MAX_HR  = 23;

    // Field shown on edit_field for a given state.
    function automatic logic [1:0] field_of(input set_state_t st);
        logic [1:0] f;
        case (st)
            ST_EDIT_H: f = FIELD_HR;
            ST_EDIT_M: f = FIELD_MIN;
            ST_EDIT_S: f = FIELD_SEC;
            default:   f = FIELD_NONE;
        endcase
        return f;
    endfunction

    // State reached by btn_mode from an edit state.
    function automatic set_state_t next_edit(input set_state_t st);
        set_state_t n;
        case (st)
            ST_EDIT_H: n = ST_EDIT_M;
            ST_EDIT_M: n = ST_EDIT_S;
            ST_EDIT_S: n = ST_COMMIT;
            default:   n = ST_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Shadow register for one time field.
// load   : capture load_val (values above MAX are clamped to 0); has priority
// inc    : increment, wrapping from MAX back to 0
// value  : registered field value
module wrap_counter #(
    parameter int WIDTH = 7,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] value_s;

    // Next field value: clamped load, or compare-and-wrap increment.
    always_comb begin
        value_s = value_r;
        if (load) begin
            if (load_val > MAX_V) begin
                value_s = ZERO_V;
            end else begin
                value_s = load_val;
            end
        end else if (inc) begin
            if (value_r >= MAX_V) begin
                value_s = ZERO_V;
            end else begin
                value_s = value_r + ONE_V;
            end
        end else begin
            value_s = value_r;
        end
    end

    // Field register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= ZERO_V;
        end else begin
            value_r <= value_s;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/clk_time_setter.sv
// Front-panel time-setting controller for the DigitalCLK set interface.
// Ports:
//   Clk_1sec, reset           : single clock, synchronous active-high reset
//   btn_mode, btn_inc         : debounced one-cycle button pulses
//   cur_hours/minutes/seconds : running time, captured when editing starts
//   setmode                   : load strobe, high LOAD_CYCLES cycles in COMMIT
//   set_hours/minutes/seconds : shadow values presented to the clock
//   edit_field                : 0 none, 1 hours, 2 minutes, 3 seconds
//   busy                      : high in any state other than RUN
module clk_time_setter
    import clk_set_defs::*;
#(
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 30
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [6:0] cur_seconds,
    input  logic [6:0] cur_minutes,
    input  logic [5:0] cur_hours,
    output logic       setmode,
    output logic [6:0] set_seconds,
    output logic [6:0] set_minutes,
    output logic [5:0] set_hours,
    output logic [1:0] edit_field,
    output logic       busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int CMT_W = $clog2(LOAD_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CMT_W-1:0] CMT_LAST = CMT_W'(LOAD_CYCLES - 1);

    set_state_t       state_r, state_s;
    logic [TMO_W-1:0] tmo_r, tmo_s;
    logic [CMT_W-1:0] cmt_r, cmt_s;
    logic             capture_s;
    logic             inc_h_s, inc_m_s, inc_sec_s;
    logic             setmode_r, busy_r;
    logic [1:0]       edit_field_r;

    // Next-state, timeout and commit counter logic.
    always_comb begin
        state_s   = state_r;
        tmo_s     = tmo_r;
        cmt_s     = cmt_r;
        capture_s = 1'b0;
        inc_h_s   = 1'b0;
        inc_m_s   = 1'b0;
        inc_sec_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                tmo_s = {TMO_W{1'b0}};
                cmt_s = {CMT_W{1'b0}};
                if (btn_mode) begin
                    capture_s = 1'b1;
                    state_s   = ST_EDIT_H;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                // btn_mode wins over a same-cycle btn_inc.
                if (btn_mode) begin
                    state_s = next_edit(state_r);
                    tmo_s   = {TMO_W{1'b0}};
                    cmt_s   = {CMT_W{1'b0}};
                end else if (btn_inc) begin
                    inc_h_s   = (state_r == ST_EDIT_H);
                    inc_m_s   = (state_r == ST_EDIT_M);
                    inc_sec_s = (state_r == ST_EDIT_S);
                    tmo_s     = {TMO_W{1'b0}};
                end else if (tmo_r == TMO_LAST) begin
                    // TIMEOUT idle cycles: abandon the edit without loading.
                    state_s = ST_RUN;
                    tmo_s   = {TMO_W{1'b0}};
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            ST_COMMIT: begin
                if (cmt_r == CMT_LAST) begin
                    state_s = ST_RUN;
                    cmt_s   = {CMT_W{1'b0}};
                end else begin
                    cmt_s = cmt_r + CMT_W'(1);
                end
            end
            default: begin
                state_s = ST_RUN;
                tmo_s   = {TMO_W{1'b0}};
                cmt_s   = {CMT_W{1'b0}};
            end
        endcase
    end

    // State, counters and outputs registered from the next state so each
    // output changes on the same edge as the state it reflects.
    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            state_r      <= ST_RUN;
            tmo_r        <= {TMO_W{1'b0}};
            cmt_r        <= {CMT_W{1'b0}};
            setmode_r    <= 1'b0;
            busy_r       <= 1'b0;
            edit_field_r <= FIELD_NONE;
        end else begin
            state_r      <= state_s;
            tmo_r        <= tmo_s;
            cmt_r        <= cmt_s;
            setmode_r    <= (state_s == ST_COMMIT);
            busy_r       <= (state_s != ST_RUN);
            edit_field_r <= field_of(state_s);
        end
    end

    wrap_counter #(.WIDTH(6), .MAX(MAX_HR)) u_hours (
        .clk      (Clk_1sec),
        .reset    (reset),
        .load     (capture_s),
        .load_val (cur_hours),
        .inc      (inc_h_s),
        .value    (set_hours)
    );

    wrap_counter #(.WIDTH(7), .MAX(MAX_MIN)) u_minutes (
        .clk      (Clk_1sec),
        .reset    (reset),
        .load     (capture_s),
        .load_val (cur_minutes),
        .inc      (inc_m_s),
        .value    (set_minutes)
    );

    wrap_counter #(.WIDTH(7), .MAX(MAX_SEC)) u_seconds (
        .clk      (Clk_1sec),
        .reset    (reset),
        .load     (capture_s),
        .load_val (cur_seconds),
        .inc      (inc_sec_s),
        .value    (set_seconds)
    );

    assign setmode    = setmode_r;
    assign busy       = busy_r;
    assign edit_field = edit_field_r;

endmodule

// File: tb/tb_clk_time_setter.sv
// Directed testbench for clk_time_setter.
// Observed vector layout: {setmode, busy, edit_field[1:0], hours[5:0],
// minutes[6:0], seconds[6:0]}.
module tb_clk_time_setter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [6:0] cur_seconds = 7'd0;
    logic [6:0] cur_minutes = 7'd0;
    logic [5:0] cur_hours = 6'd0;
    logic       setmode;
    logic [6:0] set_seconds;
    logic [6:0] set_minutes;
    logic [5:0] set_hours;
    logic [1:0] edit_field;
    logic       busy;

    logic [23:0] obs;
    logic [23:0] exp_v;
    int n_cmp = 0;
    int n_err = 0;

    assign obs = {setmode, busy, edit_field, set_hours, set_minutes, set_seconds};

    always #5 clk = ~clk;

    clk_time_setter #(.LOAD_CYCLES(2), .TIMEOUT(30)) dut (
        .Clk_1sec    (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .cur_seconds (cur_seconds),
        .cur_minutes (cur_minutes),
        .cur_hours   (cur_hours),
        .setmode     (setmode),
        .set_seconds (set_seconds),
        .set_minutes (set_minutes),
        .set_hours   (set_hours),
        .edit_field  (edit_field),
        .busy        (busy)
    );

    // Apply buttons for one clock edge, then sample 1 time unit after it.
    task automatic step(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        reset = 1'b0;
        exp_v = {1'b0, 1'b0, 2'd0, 6'd0, 7'd0, 7'd0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_basic_set();
        cur_hours = 6'd6; cur_minutes = 7'd6; cur_seconds = 7'd6;
        step(1'b1, 1'b0);
        cur_hours = 6'd1; cur_minutes = 7'd2; cur_seconds = 7'd3;
        exp_v = {1'b0, 1'b1, 2'd1, 6'd6, 7'd6, 7'd6};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL basic_capture: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        exp_v = {1'b0, 1'b1, 2'd1, 6'd8, 7'd6, 7'd6};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL basic_inc_hours: got %h expected %h", obs, exp_v); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        exp_v = {1'b0, 1'b1, 2'd2, 6'd8, 7'd7, 7'd6};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL basic_inc_minutes: got %h expected %h", obs, exp_v); end
        step(1'b1, 1'b0);
        exp_v = {1'b0, 1'b1, 2'd3, 6'd8, 7'd7, 7'd6};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL basic_edit_sec: got %h expected %h", obs, exp_v); end
        step(1'b1, 1'b0);
        exp_v = {1'b1, 1'b1, 2'd0, 6'd8, 7'd7, 7'd6};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL basic_commit1: got %h expected %h", obs, exp_v); end
        // Buttons are ignored during COMMIT.
        step(1'b1, 1'b1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL basic_commit2: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b0);
        exp_v = {1'b0, 1'b0, 2'd0, 6'd8, 7'd7, 7'd6};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL basic_done: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_wrap();
        cur_hours = 6'd23; cur_minutes = 7'd59; cur_seconds = 7'd59;
        step(1'b1, 1'b0);
        exp_v = {1'b0, 1'b1, 2'd1, 6'd23, 7'd59, 7'd59};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_capture: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b1);
        exp_v = {1'b0, 1'b1, 2'd1, 6'd0, 7'd59, 7'd59};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_hours: got %h expected %h", obs, exp_v); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        exp_v = {1'b0, 1'b1, 2'd2, 6'd0, 7'd0, 7'd59};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_minutes: got %h expected %h", obs, exp_v); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        exp_v = {1'b0, 1'b1, 2'd3, 6'd0, 7'd0, 7'd0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_seconds: got %h expected %h", obs, exp_v); end
        step(1'b1, 1'b0);
        exp_v = {1'b1, 1'b1, 2'd0, 6'd0, 7'd0, 7'd0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_commit: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        exp_v = {1'b0, 1'b0, 2'd0, 6'd0, 7'd0, 7'd0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_done: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_clamp_simul();
        cur_hours = 6'd30; cur_minutes = 7'd60; cur_seconds = 7'd45;
        step(1'b1, 1'b0);
        exp_v = {1'b0, 1'b1, 2'd1, 6'd0, 7'd0, 7'd45};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clamp_capture: got %h expected %h", obs, exp_v); end
        step(1'b1, 1'b1);
        exp_v = {1'b0, 1'b1, 2'd2, 6'd0, 7'd0, 7'd45};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL simul_mode_wins: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        exp_v = {1'b1, 1'b1, 2'd0, 6'd0, 7'd1, 7'd45};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clamp_commit: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        exp_v = {1'b0, 1'b0, 2'd0, 6'd0, 7'd1, 7'd45};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clamp_done: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_timeout();
        logic seen_set;
        seen_set = 1'b0;
        cur_hours = 6'd10; cur_minutes = 7'd20; cur_seconds = 7'd30;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < 28; k++) begin
            step(1'b0, 1'b0);
            seen_set = seen_set | setmode;
        end
        // Pulse on idle cycle 29 restarts the count.
        step(1'b0, 1'b1);
        seen_set = seen_set | setmode;
        for (int k = 0; k < 29; k++) begin
            step(1'b0, 1'b0);
            seen_set = seen_set | setmode;
        end
        exp_v = {1'b0, 1'b1, 2'd2, 6'd10, 7'd21, 7'd30};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL timeout_restart: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b0);
        seen_set = seen_set | setmode;
        exp_v = {1'b0, 1'b0, 2'd0, 6'd10, 7'd21, 7'd30};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL timeout_abort: got %h expected %h", obs, exp_v); end
        // Plain timeout of exactly 30 idle cycles from EDIT_H.
        step(1'b1, 1'b0);
        for (int k = 0; k < 29; k++) begin
            step(1'b0, 1'b0);
            seen_set = seen_set | setmode;
        end
        exp_v = {1'b0, 1'b1, 2'd1, 6'd10, 7'd20, 7'd30};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL timeout_29: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b0);
        seen_set = seen_set | setmode;
        exp_v = {1'b0, 1'b0, 2'd0, 6'd10, 7'd20, 7'd30};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL timeout_30: got %h expected %h", obs, exp_v); end
        n_cmp++;
        if (seen_set !== 1'b0) begin n_err++; $display("FAIL timeout_no_setmode: got %b expected 0", seen_set); end
    endtask

    task automatic test_run_ignores_inc();
        exp_v = {1'b0, 1'b0, 2'd0, 6'd10, 7'd20, 7'd30};
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL run_inc_%0d: got %h expected %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_reset_commit();
        cur_hours = 6'd1; cur_minutes = 7'd2; cur_seconds = 7'd3;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        exp_v = {1'b1, 1'b1, 2'd0, 6'd1, 7'd2, 7'd3};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstc_commit: got %h expected %h", obs, exp_v); end
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        exp_v = {1'b0, 1'b0, 2'd0, 6'd0, 7'd0, 7'd0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstc_reset: got %h expected %h", obs, exp_v); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstc_no_load: got %h expected %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_basic_set();
        test_wrap();
        test_clamp_simul();
        test_timeout();
        test_run_ignores_inc();
        test_reset_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
